conv2_dw: RTL and testbench

Depthwise 3x3 convolution stage of CONV2; sits directly upstream of the CONV2 pointwise stage. Reads the 14x14x64 int8 feature map from fmap bank 0x0000 and the 64 depthwise 3x3 kernels from param bank 0x1240–0x147F. Writes the 7x7x64 int8 result to fmap bank 0x4000, where the pointwise stage consumes it. One output word per 12 cycles; `done` hands control to the pointwise stage.

---
 rtl/conv2_dw.sv | 188 ++++++++++++++++++
 tb/tb_conv2_dw.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_dw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : conv2_dw                                                       |
// | Brief   : CONV2 depthwise 3x3 stage (stride 2, pad 1). Reads the int8    |
// |           fmap and per-channel kernels, writes one saturated int8 word   |
// |           every 12 cycles, then pulses done for the pointwise stage.     |
// |           Optional: define CONV2_DW_RELU_EN to clamp results at zero.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module conv2_dw #(
   parameter int          FMAP_SIZE = 14,
   parameter int          CHANNEL   = 64,
   parameter int          OUT_SIZE  = 7,
   parameter logic [15:0] W_BASE    = 16'h1240,
   parameter logic [14:0] IN_BASE   = 15'h0000,
   parameter logic [14:0] OUT_BASE  = 15'h4000,
   parameter int          SHIFT     = 7
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        init,
   output logic        done,
   output logic [15:0] pbank_addr,
   input  logic [7:0]  pdata,
   output logic        pbank_en,
   output logic [14:0] fbank_raddr,
   input  logic [7:0]  fdata_r,
   output logic        fbank_ren,
   output logic [14:0] fbank_waddr,
   output logic [7:0]  fdata_w,
   output logic        fbank_wen
);

   localparam int CW = $clog2(CHANNEL);
   localparam int PW = $clog2(OUT_SIZE);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   chan, chan_nx;
   logic [PW-1:0]   oh, oh_nx, ow, ow_nx;
   logic [3:0]      tap, tap_nx;
   logic            dcnt, dcnt_nx;
   logic            last_px;

   int              kh, kw, ih, iw;
   logic            tap_ok;
   logic [14:0]     raddr_nx;
   logic [15:0]     paddr_nx;
   logic [14:0]     waddr_cur;

   logic            vp1, vp2;
   logic signed [15:0] prod;
   logic signed [19:0] acc, acc_nx, shifted;
   logic [7:0]      sat_val, wdata;

   assign last_px = (chan == CW'(CHANNEL - 1)) && (oh == PW'(OUT_SIZE - 1)) &&
                    (ow == PW'(OUT_SIZE - 1));

   // Next state and loop counters; outputs below are registered from these
   // so every address/enable lines up with the state it belongs to.
   always_comb begin
      state_nx = state;
      chan_nx  = chan;
      oh_nx    = oh;
      ow_nx    = ow;
      tap_nx   = tap;
      dcnt_nx  = dcnt;
      case (state)
         IDLE: if (init) begin
            state_nx = ISSUE;
            chan_nx  = '0;
            oh_nx    = '0;
            ow_nx    = '0;
            tap_nx   = '0;
         end
         ISSUE: if (tap == 4'd8) begin
            state_nx = DRAIN;
            dcnt_nx  = 1'b0;
         end else begin
            tap_nx = tap + 4'd1;
         end
         DRAIN: if (dcnt) state_nx = WRITE;
                else      dcnt_nx  = 1'b1;
         WRITE: begin
            tap_nx = '0;
            if (last_px) begin
               state_nx = FIN;
            end else begin
               state_nx = ISSUE;
               if (ow == PW'(OUT_SIZE - 1)) begin
                  ow_nx = '0;
                  if (oh == PW'(OUT_SIZE - 1)) begin
                     oh_nx   = '0;
                     chan_nx = chan + CW'(1);
                  end else begin
                     oh_nx = oh + PW'(1);
                  end
               end else begin
                  ow_nx = ow + PW'(1);
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Tap geometry for the tap about to be issued; padding taps are suppressed.
   always_comb begin
      kh       = int'(tap_nx) / 3;
      kw       = int'(tap_nx) % 3;
      ih       = 2 * int'(oh_nx) - 1 + kh;
      iw       = 2 * int'(ow_nx) - 1 + kw;
      tap_ok   = (state_nx == ISSUE) && (ih >= 0) && (ih < FMAP_SIZE) &&
                 (iw >= 0) && (iw < FMAP_SIZE);
      raddr_nx = IN_BASE + 15'(int'(chan_nx) * FMAP_SIZE * FMAP_SIZE +
                               ih * FMAP_SIZE + iw);
      paddr_nx = W_BASE + 16'(int'(chan_nx) * 9 + int'(tap_nx));
      waddr_cur = OUT_BASE + 15'(int'(chan) * OUT_SIZE * OUT_SIZE +
                                 int'(oh) * OUT_SIZE + int'(ow));
   end

   assign prod = $signed(pdata) * $signed(fdata_r);

   // Accumulate the returning tap, then shift and saturate the running sum.
   always_comb begin
      acc_nx = acc;
      if (vp2) acc_nx = acc + 20'(prod);
      shifted = acc_nx >>> SHIFT;
      if (shifted > 20'sd127)       sat_val = 8'h7f;
      else if (shifted < -20'sd128) sat_val = 8'h80;
      else                          sat_val = shifted[7:0];
   end

`ifdef CONV2_DW_RELU_EN
   assign wdata = sat_val[7] ? 8'h00 : sat_val;
`else
   assign wdata = sat_val;
`endif

   // Main sequencer: state, counters, registered bank ports and accumulator.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         chan        <= '0;
         oh          <= '0;
         ow          <= '0;
         tap         <= '0;
         dcnt        <= 1'b0;
         vp1         <= 1'b0;
         vp2         <= 1'b0;
         acc         <= '0;
         done        <= 1'b0;
         pbank_addr  <= '0;
         pbank_en    <= 1'b0;
         fbank_raddr <= '0;
         fbank_ren   <= 1'b0;
         fbank_waddr <= '0;
         fdata_w     <= '0;
         fbank_wen   <= 1'b0;
      end else begin
         state       <= state_nx;
         chan        <= chan_nx;
         oh          <= oh_nx;
         ow          <= ow_nx;
         tap         <= tap_nx;
         dcnt        <= dcnt_nx;
         pbank_en    <= tap_ok;
         fbank_ren   <= tap_ok;
         pbank_addr  <= tap_ok ? paddr_nx : 16'h0000;
         fbank_raddr <= tap_ok ? raddr_nx : 15'h0000;
         // enable is high on the address cycle; two stages later the data arrives
         vp1         <= pbank_en;
         vp2         <= vp1;
         fbank_wen   <= (state_nx == WRITE);
         done        <= (state_nx == FIN);
         if (state_nx == WRITE) begin
            fbank_waddr <= waddr_cur;
            fdata_w     <= wdata;
         end
         if (state == IDLE || state == WRITE) acc <= '0;
         else                                 acc <= acc_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv2_dw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_conv2_dw                                                    |
// | Brief   : Bench for conv2_dw with a behavioural conv model, a 2-cycle    |
// |           latency bank model and a per-cycle compare process.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_conv2_dw;

   localparam int SH    = 0;
   localparam int NPIX  = 64 * 7 * 7;
   localparam int RUNLN = NPIX * 12;

   logic        clk = 1'b0;
   logic        rstn, init;
   logic        done;
   logic [15:0] pbank_addr;
   logic [7:0]  pdata = 8'h00;
   logic        pbank_en;
   logic [14:0] fbank_raddr;
   logic [7:0]  fdata_r = 8'h00;
   logic        fbank_ren;
   logic [14:0] fbank_waddr;
   logic [7:0]  fdata_w;
   logic        fbank_wen;

   always #5 clk = ~clk;

   conv2_dw #(.SHIFT(SH)) dut (
      .clk(clk), .rstn(rstn), .init(init), .done(done),
      .pbank_addr(pbank_addr), .pdata(pdata), .pbank_en(pbank_en),
      .fbank_raddr(fbank_raddr), .fdata_r(fdata_r), .fbank_ren(fbank_ren),
      .fbank_waddr(fbank_waddr), .fdata_w(fdata_w), .fbank_wen(fbank_wen)
   );

   // ---------------- bank contents (depend on test mode) ----------------
   int mode = 0;

   function automatic int act(int a);
      case (mode)
         0:       return 1;
         1:       return (((a * 13) ^ (a >> 3)) % 7) - 3;
         default: return 127;
      endcase
   endfunction

   function automatic int wgt(int a);
      case (mode)
         0:       return 1;
         1:       return (((a * 11) ^ (a >> 2)) % 5) - 2;
         2:       return 127;
         default: return -128;
      endcase
   endfunction

   // two-cycle read latency; disabled reads return junk that must never count
   logic [7:0] p1 = 8'h00, f1 = 8'h00;
   always @(posedge clk) begin
      p1      <= pbank_en  ? 8'(wgt(int'(pbank_addr)))  : 8'hA5;
      f1      <= fbank_ren ? 8'(act(int'(fbank_raddr))) : 8'h5A;
      pdata   <= p1;
      fdata_r <= f1;
   end

   // ---------------- behavioural model ----------------
   typedef struct { int raddr; int paddr; int cyc; } rd_t;
   typedef struct { int addr;  int data;  int cyc; } wr_t;
   rd_t rq[$];
   wr_t wq[$];

   function automatic int sat8(int v);
      int s;
      s = v >>> SH;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
`ifdef CONV2_DW_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   task automatic build();
      rd_t r;
      wr_t w;
      int  p, sum, ih, iw;
      rq.delete();
      wq.delete();
      for (int c = 0; c < 64; c++)
         for (int oh = 0; oh < 7; oh++)
            for (int ow = 0; ow < 7; ow++) begin
               p   = (c * 7 + oh) * 7 + ow;
               sum = 0;
               for (int kh = 0; kh < 3; kh++)
                  for (int kw = 0; kw < 3; kw++) begin
                     ih = 2 * oh - 1 + kh;
                     iw = 2 * ow - 1 + kw;
                     if (ih >= 0 && ih < 14 && iw >= 0 && iw < 14) begin
                        r.raddr = c * 196 + ih * 14 + iw;
                        r.paddr = 'h1240 + c * 9 + kh * 3 + kw;
                        r.cyc   = p * 12 + kh * 3 + kw;
                        rq.push_back(r);
                        sum += wgt(r.paddr) * act(r.raddr);
                     end
                  end
               w.addr = 'h4000 + c * 49 + oh * 7 + ow;
               w.data = sat8(sum);
               w.cyc  = p * 12 + 11;
               wq.push_back(w);
            end
   endtask

   // ---------------- compare process ----------------
   int n_vec = 0, n_err = 0;
   int rel = 0, writes = 0, n_done = 0;
   bit quiet = 1'b1, tmo = 1'b0, tmo_seen = 1'b0;
   rd_t cr;
   wr_t cw;

   task automatic chk(string nm, int got, int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (run cycle %0d)", nm, got, exp, rel);
      end
   endtask

   task automatic pin_model();
      int cnt0, cnt262, first_r, first_p, last_r, last_p;
      cnt0 = 0; cnt262 = 0; first_r = -1; first_p = -1; last_r = -1; last_p = -1;
      foreach (rq[i]) begin
         if (rq[i].cyc < 12) cnt0++;
         if (rq[i].cyc >= 262 * 12 && rq[i].cyc < 263 * 12) begin
            if (cnt262 == 0) begin first_r = rq[i].raddr; first_p = rq[i].paddr; end
            last_r = rq[i].raddr; last_p = rq[i].paddr;
            cnt262++;
         end
      end
      if (mode == 0) begin
         chk("model_out_0_0",    wq[0].data, 4);
         chk("model_out_0_1",    wq[1].data, 6);
         chk("model_out_3_3",    wq[24].data, 9);
         chk("model_waddr0",     wq[0].addr, 'h4000);
         chk("model_waddr1",     wq[1].addr, 'h4001);
         chk("model_waddr_5_2_3", wq[262].addr, 'h4106);
         chk("model_first_wcyc", wq[0].cyc, 11);
         chk("model_nwrites",    wq.size(), 3136);
         chk("model_corner_taps", cnt0, 4);
         chk("model_px262_taps", cnt262, 9);
         chk("model_px262_r0",   first_r, 1027);
         chk("model_px262_p0",   first_p, 'h126D);
         chk("model_px262_r8",   last_r, 1057);
         chk("model_px262_p8",   last_p, 'h1275);
      end else if (mode == 2) begin
         chk("model_sat_pos", wq[0].data, 127);
         chk("model_sat_pos_mid", wq[30].data, 127);
      end else if (mode == 3) begin
`ifdef CONV2_DW_RELU_EN
         chk("model_sat_neg_relu", wq[0].data, 0);
`else
         chk("model_sat_neg", wq[0].data, -128);
`endif
      end
   endtask

   always @(negedge clk) begin
      rel++;
      if (init) begin
         rel    = -1;
         writes = 0;
         quiet  = 1'b0;
         build();
         pin_model();
      end
      if (quiet) begin
         chk("idle_ctrl", int'({done, pbank_en, fbank_ren, fbank_wen}), 0);
         chk("idle_data", int'(pbank_addr) | int'(fbank_raddr) |
                          int'(fbank_waddr) | int'(fdata_w), 0);
      end else begin
         if (pbank_en || fbank_ren) begin
            chk("en_pair", int'(pbank_en), int'(fbank_ren));
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               cr = rq.pop_front();
               chk("rd_cycle",    rel, cr.cyc);
               chk("fbank_raddr", int'(fbank_raddr), cr.raddr);
               chk("pbank_addr",  int'(pbank_addr), cr.paddr);
            end
         end
         if (fbank_wen) begin
            chk("wen_with_ren", int'(fbank_ren), 0);
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               cw = wq.pop_front();
               chk("wr_cycle",    rel, cw.cyc);
               chk("fbank_waddr", int'(fbank_waddr), cw.addr);
               chk("fdata_w",     int'($signed(fdata_w)), cw.data);
            end
            writes++;
         end
         if (done) begin
            n_done++;
            chk("done_cycle",    rel, RUNLN);
            chk("write_count",   writes, NPIX);
            chk("writes_left",   wq.size(), 0);
         end
      end
      if (tmo && !tmo_seen) begin
         tmo_seen = 1'b1;
         chk("done_timeout", 0, 1);
      end
      if (!rstn) begin
         if (!quiet)
            chk("writes_before_reset", writes, (rel >= 11) ? (rel - 11) / 12 + 1 : 0);
         quiet = 1'b1;
         rq.delete();
         wq.delete();
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(int m);
      mode = m;
      init = 1'b1;
      step();
      init = 1'b0;
   endtask

   task automatic abort_after(int cycles);
      repeat (cycles - 1) step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      repeat (50) step();
   endtask

   initial begin
      int d0;
      rstn = 1'b0;
      init = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      repeat (100) step();

      // full run with unit data
      d0 = n_done;
      start(0);
      for (int i = 0; i < RUNLN + 100 && n_done == d0; i++) step();
      if (n_done == d0) begin
         tmo = 1'b1;
         repeat (2) step();
      end

      // second init straight after done, mixed-sign data, reset at cycle 500
      start(1);
      abort_after(500);

      // saturation runs, each restarting from the base address after a reset
      start(2);
      abort_after(300);
      start(3);
      abort_after(300);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
